p2s_arbiter: RTL

- Shares one p2s serializer (MOSI / CS_N style) between NUM_REQ requesters.
- Each requester pushes a packet of one or more WIDTH-bit words.
- Block arbitrates round-robin and locks the serializer to the winner until its last word.
- Per word: pulses the serializer start, waits for the serializer to leave and then re-enter idle; frames each packet with an active-low select.
- Sits between host-side command sources and the p2s instance.

---
 rtl/p2s_arbiter_pkg.sv | 20 ++
 rtl/p2s_arbiter_rr_pick.sv | 29 ++
 rtl/p2s_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/p2s_arbiter_pkg.sv
// Shared types and helpers for the p2s serializer arbiter.
package p2s_arbiter_pkg;

    typedef enum logic [1:0] {ARB, LOAD, WAIT_BUSY, WAIT_IDLE} state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int MAX_REQ     = 8;

    // OR of set-bit positions; exact for a one-hot input.
    function automatic logic [2:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/p2s_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after the pointer, wrapping.
module rr_pick
    import p2s_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_any
);

    always_comb begin
        int idx;
        o_gnt = '0;
        o_any = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!o_any && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/p2s_arbiter.sv
// Round-robin arbiter that locks one p2s serializer to a requester for a whole packet.
// Optional per-word timeout abort: define P2S_ARBITER_TIMEOUT_EN.
module p2s_arbiter
    import p2s_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
`ifdef P2S_ARBITER_TIMEOUT_EN
   ,parameter int TIMEOUT = 1023
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*WIDTH-1:0] i_data,
    input  logic [NUM_REQ-1:0]       i_last,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_frame_n,
    output logic [WIDTH-1:0]         o_ser_d,
    output logic                     o_ser_run,
    input  logic                     i_ser_idle
`ifdef P2S_ARBITER_TIMEOUT_EN
   ,output logic                     o_err
`endif
);

    localparam int PW = $clog2(NUM_REQ);

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt, r_ack, w_ack_nxt;
    logic                 r_frame_n, w_frame_n_nxt, r_ser_run, w_ser_run_nxt;
    logic                 r_last_q, w_last_q_nxt, w_load;
    logic [WIDTH-1:0]     r_ser_d, w_ser_d_nxt;
    logic [PW-1:0]        r_ptr, w_ptr_nxt, w_load_idx, w_owner_idx, w_rel_ptr;
    logic [NUM_REQ-1:0]   w_pick, w_load_oh;
    logic                 w_any;

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick),
        .o_any (w_any)
    );

    // In ARB the word comes from the new winner, otherwise from the current owner.
    assign w_load_oh   = (r_state == ARB) ? w_pick : r_grant;
    assign w_load_idx  = PW'(oh2idx(MAX_REQ'(w_load_oh)));
    assign w_owner_idx = PW'(oh2idx(MAX_REQ'(r_grant)));
    assign w_rel_ptr   = (w_owner_idx == PW'(NUM_REQ-1)) ? '0 : w_owner_idx + 1'b1;

`ifdef P2S_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] r_cnt;
    logic          r_err, w_err_nxt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n)                                     r_cnt <= '0;
        else if (r_state == LOAD)                           r_cnt <= '0;
        else if (r_state == WAIT_BUSY || r_state == WAIT_IDLE) r_cnt <= r_cnt + 1'b1;
        r_err <= i_reset_n & w_err_nxt;
    end

    assign o_err = r_err;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_frame_n_nxt = r_frame_n;
        w_ser_d_nxt   = r_ser_d;
        w_ptr_nxt     = r_ptr;
        w_last_q_nxt  = r_last_q;
        w_ack_nxt     = '0;
        w_ser_run_nxt = 1'b0;
        w_load        = 1'b0;
`ifdef P2S_ARBITER_TIMEOUT_EN
        w_err_nxt     = 1'b0;
`endif
        case (r_state)
            ARB: begin
                w_grant_nxt   = '0;
                w_frame_n_nxt = 1'b1;
                if (i_ser_idle && w_any) begin
                    w_grant_nxt   = w_pick;
                    w_frame_n_nxt = 1'b0;
                    w_state_nxt   = LOAD;
                    w_load        = 1'b1;
                end
            end
            LOAD:      w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (!i_ser_idle) w_state_nxt = WAIT_IDLE;
            WAIT_IDLE: begin
                if (i_ser_idle) begin
                    if (r_last_q) begin
                        w_grant_nxt   = '0;
                        w_frame_n_nxt = 1'b1;
                        w_ptr_nxt     = w_rel_ptr;
                        w_state_nxt   = ARB;
                    end else if (|(i_req & r_grant)) begin
                        w_state_nxt = LOAD;
                        w_load      = 1'b1;
                    end
                end
            end
            default:   w_state_nxt = ARB;
        endcase

        // Registered outputs go active for exactly the LOAD cycle.
        if (w_load) begin
            w_ser_run_nxt = 1'b1;
            w_ser_d_nxt   = i_data[w_load_idx*WIDTH +: WIDTH];
            w_ack_nxt     = w_load_oh;
            w_last_q_nxt  = |(i_last & w_load_oh);
        end

`ifdef P2S_ARBITER_TIMEOUT_EN
        if ((r_state == WAIT_BUSY || r_state == WAIT_IDLE) && r_cnt == CW'(TIMEOUT-1)) begin
            w_err_nxt     = 1'b1;
            w_grant_nxt   = '0;
            w_frame_n_nxt = 1'b1;
            w_ptr_nxt     = w_rel_ptr;
            w_state_nxt   = ARB;
            w_ser_run_nxt = 1'b0;
            w_ack_nxt     = '0;
            w_ser_d_nxt   = r_ser_d;
            w_last_q_nxt  = r_last_q;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= ARB;
            r_grant   <= '0;
            r_ack     <= '0;
            r_frame_n <= 1'b1;
            r_ser_run <= 1'b0;
            r_ser_d   <= '0;
            r_ptr     <= '0;
            r_last_q  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ack     <= w_ack_nxt;
            r_frame_n <= w_frame_n_nxt;
            r_ser_run <= w_ser_run_nxt;
            r_ser_d   <= w_ser_d_nxt;
            r_ptr     <= w_ptr_nxt;
            r_last_q  <= w_last_q_nxt;
        end
    end

    assign o_ack     = r_ack;
    assign o_grant   = r_grant;
    assign o_frame_n = r_frame_n;
    assign o_ser_d   = r_ser_d;
    assign o_ser_run = r_ser_run;

endmodule
